// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enable writes, optional zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the same-cycle write onto matching read ports.
module reg_file_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wrAddr,
   input  logic [DATA_W-1:0]          wrData,
   input  logic [DATA_W/8-1:0]        wrByteEn,
   input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
   output logic [NUM_RD*DATA_W-1:0]   rdData,
   output logic [NUM_RD-1:0]          rdBusy,
   input  logic                       issueEn,
   input  logic [ADDR_W-1:0]          issueAddr,
   output logic [ADDR_W:0]            busyCnt
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned LANES = DATA_W/8;
   localparam int unsigned CNT_W = ADDR_W+1;
   localparam bit          HAS_ZERO = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busyNext;
   logic [DATA_W-1:0] wrMask;
   logic              wrValid;
   logic              issueValid;

   function automatic logic [CNT_W-1:0] popCount(input logic [DEPTH-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   // Expand byte enables into a bit mask
   always_comb begin
      wrMask = '0;
      for (int i = 0; i < LANES; i++) begin
         wrMask[8*i +: 8] = {8{wrByteEn[i]}};
      end
   end

   // Accesses to the hardwired zero register are dropped up front
   assign wrValid    = we      && !(HAS_ZERO && (wrAddr    == '0));
   assign issueValid = issueEn && !(HAS_ZERO && (issueAddr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wrValid) begin
         regs[wrAddr] <= (regs[wrAddr] & ~wrMask) | (wrData & wrMask);
      end
   end

   // Issue is applied after write-back so a new producer supersedes the retiring one
   always_comb begin
      busyNext = busy;
      if (wrValid) begin
         busyNext[wrAddr] = 1'b0;
      end
      if (issueValid) begin
         busyNext[issueAddr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= '0;
         busyCnt <= '0;
      end else begin
         busy    <= busyNext;
         busyCnt <= popCount(busyNext);
      end
   end

   always_comb begin
      rdData = '0;
      rdBusy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rdData[k*DATA_W +: DATA_W] = regs[rdAddr[k*ADDR_W +: ADDR_W]];
         rdBusy[k]                  = busy[rdAddr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
         if (wrValid && (wrAddr == rdAddr[k*ADDR_W +: ADDR_W])) begin
            rdData[k*DATA_W +: DATA_W] = (regs[wrAddr] & ~wrMask) | (wrData & wrMask);
            rdBusy[k]                  = issueValid && (issueAddr == wrAddr);
         end
`endif
         if (HAS_ZERO && (rdAddr[k*ADDR_W +: ADDR_W] == '0)) begin
            rdData[k*DATA_W +: DATA_W] = '0;
            rdBusy[k]                  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array/queue-level reference model.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_reg_file_mp;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default-parameter instance
   logic        we;
   logic [4:0]  wrAddr;
   logic [31:0] wrData;
   logic [3:0]  wrByteEn;
   logic [9:0]  rdAddr;
   logic [63:0] rdData;
   logic [1:0]  rdBusy;
   logic        issueEn;
   logic [4:0]  issueAddr;
   logic [5:0]  busyCnt;

   // wide 4-port instance
   logic         we4;
   logic [3:0]   wrAddr4;
   logic [63:0]  wrData4;
   logic [7:0]   wrByteEn4;
   logic [15:0]  rdAddr4;
   logic [255:0] rdData4;
   logic [3:0]   rdBusy4;
   logic         issueEn4;
   logic [3:0]   issueAddr4;
   logic [4:0]   busyCnt4;

   reg_file_mp dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wrAddr(wrAddr), .wrData(wrData),
      .wrByteEn(wrByteEn), .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy),
      .issueEn(issueEn), .issueAddr(issueAddr), .busyCnt(busyCnt)
   );

   reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .we(we4), .wrAddr(wrAddr4), .wrData(wrData4),
      .wrByteEn(wrByteEn4), .rdAddr(rdAddr4), .rdData(rdData4), .rdBusy(rdBusy4),
      .issueEn(issueEn4), .issueAddr(issueAddr4), .busyCnt(busyCnt4)
   );

   int nCmp = 0;
   int nErr = 0;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference model: architectural registers and set of in-flight destinations
   logic [31:0] mem [32];
   bit          mBusy [32];

   function automatic int mCount();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(mBusy[i]);
      return c;
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 32; i++) begin
         mem[i]   = 32'h0;
         mBusy[i] = 1'b0;
      end
   endfunction

   function automatic logic [31:0] expData(input logic [4:0] a);
      logic [31:0] d;
      if (a == 5'd0) return 32'h0;
      d = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (we && wrAddr == a)
         for (int b = 0; b < 4; b++)
            if (wrByteEn[b]) d[8*b +: 8] = wrData[8*b +: 8];
`endif
      return d;
   endfunction

   function automatic logic expBusy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (we && wrAddr == a) return issueEn && (issueAddr == wrAddr);
`endif
      return mBusy[a];
   endfunction

   function automatic void modelUpdate();
      if (we && wrAddr != 5'd0) begin
         for (int b = 0; b < 4; b++)
            if (wrByteEn[b]) mem[wrAddr][8*b +: 8] = wrData[8*b +: 8];
         mBusy[wrAddr] = 1'b0;
      end
      if (issueEn && issueAddr != 5'd0) mBusy[issueAddr] = 1'b1;
   endfunction

   task automatic compareAll(input string tag);
      for (int k = 0; k < 2; k++) begin
         checkEq($sformatf("%s/data%0d", tag, k), 64'(rdData[k*32 +: 32]), 64'(expData(rdAddr[k*5 +: 5])));
         checkEq($sformatf("%s/busy%0d", tag, k), 64'(rdBusy[k]), 64'(expBusy(rdAddr[k*5 +: 5])));
      end
      checkEq($sformatf("%s/cnt", tag), 64'(busyCnt), 64'(mCount()));
   endtask

   // called at a falling edge with inputs set; checks, clocks, then idles controls
   task automatic cycle(input string tag);
      #1 compareAll(tag);
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      we       = 1'b0;
      issueEn  = 1'b0;
      wrByteEn = 4'h0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] en);
      we = 1'b1; wrAddr = a; wrData = d; wrByteEn = en;
      cycle("wr");
   endtask

   logic [63:0] v64;

   initial begin
      rst_n = 1'b0;
      we = 1'b0; wrAddr = '0; wrData = '0; wrByteEn = '0; rdAddr = '0; issueEn = 1'b0; issueAddr = '0;
      we4 = 1'b0; wrAddr4 = '0; wrData4 = '0; wrByteEn4 = '0; rdAddr4 = '0; issueEn4 = 1'b0; issueAddr4 = '0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rdAddr = {5'd1, 5'd2};
      #1;
      checkEq("rst/data", rdData, 64'h0);
      checkEq("rst/busy", 64'(rdBusy), 64'h0);
      checkEq("rst/cnt", 64'(busyCnt), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: fill, issue, then reset asserted mid-cycle during a write
      for (int a = 0; a < 32; a++) wr(5'(a), 32'hFFFF_FFFF, 4'hF);
      issueEn = 1'b1; issueAddr = 5'd5; rdAddr = {5'd5, 5'd6};
      cycle("t1iss");
      we = 1'b1; wrAddr = 5'd6; wrData = 32'h1234_5678; wrByteEn = 4'hF;
      issueEn = 1'b1; issueAddr = 5'd7;
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      checkEq("t1/cnt", 64'(busyCnt), 64'h0);
      for (int a = 0; a < 32; a += 2) begin
         rdAddr = {5'(a + 1), 5'(a)};
         #1;
         checkEq($sformatf("t1/data%0d", a), rdData, 64'h0);
         checkEq($sformatf("t1/busy%0d", a), 64'(rdBusy), 64'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      we = 1'b0; issueEn = 1'b0; wrByteEn = 4'h0;
      rdAddr = {5'd5, 5'd6};
      cycle("t1post");

      // T2: walking one
      for (int n = 0; n < 32; n++) wr(5'(n), 32'd1 << n, 4'hF);
      for (int n = 0; n < 32; n++) begin
         int m;
         m = (n + 1) % 32;
         rdAddr = {5'(m), 5'(n)};
         #1;
         checkEq($sformatf("walk%0d", n), 64'(rdData[31:0]), (n == 0) ? 64'h0 : (64'd1 << n));
         checkEq($sformatf("walk%0d", m), 64'(rdData[63:32]), (m == 0) ? 64'h0 : (64'd1 << m));
         cycle("walk");
      end

      // T3: byte enables
      wr(5'd7, 32'h1122_3344, 4'hF);
      wr(5'd7, 32'hAABB_CCDD, 4'b0101);
      rdAddr = {5'd7, 5'd7};
      #1;
      checkEq("be/p0", 64'(rdData[31:0]), 64'h11BB_33DD);
      checkEq("be/p1", 64'(rdData[63:32]), 64'h11BB_33DD);
      cycle("be");

      // T4: scoreboard
      issueEn = 1'b1; issueAddr = 5'd3; cycle("sb1");
      issueEn = 1'b1; issueAddr = 5'd9; cycle("sb2");
      rdAddr = {5'd9, 5'd3};
      #1;
      checkEq("sb/cnt2", 64'(busyCnt), 64'd2);
      checkEq("sb/busy2", 64'(rdBusy), 64'h3);
      cycle("sb3");
      we = 1'b1; wrAddr = 5'd3; wrData = $urandom; wrByteEn = 4'h0;
      cycle("sb4");
      #1;
      checkEq("sb/cnt1", 64'(busyCnt), 64'd1);
      checkEq("sb/busy1", 64'(rdBusy), 64'h2);
      checkEq("sb/r3keep", 64'(rdData[31:0]), 64'h8);
      cycle("sb5");
      issueEn = 1'b1; issueAddr = 5'd9; we = 1'b1; wrAddr = 5'd9; wrData = 32'h99; wrByteEn = 4'hF;
      cycle("sb6");
      #1;
      checkEq("sb/cntSame", 64'(busyCnt), 64'd1);
      checkEq("sb/r9busy", 64'(rdBusy[1]), 64'd1);
      cycle("sb7");

      // T5: write-to-read in the same cycle
      wr(5'd4, 32'd5, 4'hF);
      we = 1'b1; wrAddr = 5'd4; wrData = 32'd9; wrByteEn = 4'hF; rdAddr = {5'd0, 5'd4};
      #1;
`ifdef REGFILE_BYPASS_EN
      checkEq("byp/same", 64'(rdData[31:0]), 64'd9);
`else
      checkEq("byp/same", 64'(rdData[31:0]), 64'd5);
`endif
      cycle("byp");
      #1;
      checkEq("byp/next", 64'(rdData[31:0]), 64'd9);
      cycle("byp2");

      // T6: wide 4-port configuration
      v64 = {$urandom, $urandom};
      we4 = 1'b1; wrAddr4 = 4'd6; wrData4 = v64; wrByteEn4 = 8'hFF;
      @(posedge clk); @(negedge clk);
      we4 = 1'b0; rdAddr4 = {4{4'd6}};
      #1;
      for (int k = 0; k < 4; k++) checkEq($sformatf("mp/port%0d", k), rdData4[k*64 +: 64], v64);
      we4 = 1'b1; wrAddr4 = 4'd0; wrData4 = '1; wrByteEn4 = 8'hFF;
      issueEn4 = 1'b1; issueAddr4 = 4'd0; rdAddr4 = '0;
      @(posedge clk); @(negedge clk);
      we4 = 1'b0; issueEn4 = 1'b0;
      #1;
      checkEq("mp/r0busy", 64'(rdBusy4), 64'h0);
      checkEq("mp/r0cnt", 64'(busyCnt4), 64'h0);
      checkEq("mp/r0data", rdData4[63:0], 64'h0);
      issueEn4 = 1'b1; issueAddr4 = 4'd2; rdAddr4 = {4'd0, 4'd2, 4'd6, 4'd2};
      @(posedge clk); @(negedge clk);
      issueEn4 = 1'b0;
      #1;
      checkEq("mp/cnt", 64'(busyCnt4), 64'd1);
      checkEq("mp/busy", 64'(rdBusy4), 64'h5);
      @(negedge clk);

      // randomized traffic, addresses biased to provoke collisions
      for (int i = 0; i < 600; i++) begin
         we        = 1'($urandom);
         wrAddr    = ($urandom % 2 == 0) ? 5'($urandom % 8) : 5'($urandom);
         wrData    = $urandom;
         wrByteEn  = 4'($urandom);
         issueEn   = ($urandom % 3 == 0);
         issueAddr = 5'($urandom % 8);
         rdAddr[4:0] = ($urandom % 4 == 0) ? wrAddr : 5'($urandom % 12);
         rdAddr[9:5] = ($urandom % 4 == 0) ? wrAddr : 5'($urandom);
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
